// File: rtl/wb_arbiter_pkg.sv
// Shared register-file constants and helpers for the writeback arbiter slice.
package wb_arbiter_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_DATA_W = 32;

   localparam int unsigned LU_FIFO_DEPTH   = 4;
   localparam int unsigned LU_STARVE_LIMIT = 8;

   localparam logic [REG_ADDR_W-1:0] REG_NOP       = '0;
   localparam logic [REG_DATA_W-1:0] ZERO_WORD     = '0;
   localparam logic                  WRITE_ENABLE  = 1'b1;
   localparam logic                  WRITE_DISABLE = 1'b0;
   localparam logic                  RST_ENABLE    = 1'b0;

   // A write to r0 is architecturally a no-op, so it never counts as a request.
   function automatic logic reg_write_req(input logic                  wreg,
                                          input logic [REG_ADDR_W-1:0] wa);
      return wreg && (wa != REG_NOP);
   endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: pipeline and long-unit sources in, regfile write port and stall out.
interface wb_arbiter_if;
   import wb_arbiter_pkg::*;

   logic                  mem_wreg;
   logic [REG_ADDR_W-1:0] mem_wa;
   logic [REG_DATA_W-1:0] mem_wd;

   logic                  lu_valid;
   logic [REG_ADDR_W-1:0] lu_wa;
   logic [REG_DATA_W-1:0] lu_wd;
   logic                  lu_ready;

   logic [REG_ADDR_W-1:0] wa;
   logic [REG_DATA_W-1:0] wd;
   logic                  we;
   logic                  stallreq;

   // Pipeline / long-unit side.
   modport master (
      output mem_wreg, mem_wa, mem_wd,
      output lu_valid, lu_wa, lu_wd,
      input  lu_ready,
      input  wa, wd, we, stallreq
   );

   // Arbiter side.
   modport slave (
      input  mem_wreg, mem_wa, mem_wd,
      input  lu_valid, lu_wa, lu_wd,
      output lu_ready,
      output wa, wd, we, stallreq
   );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of long-unit results with a per-entry valid tag that can be
// cleared by destination address (WAW squash) while the entry keeps its slot.
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = LU_FIFO_DEPTH
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push_en,
   input  logic [REG_ADDR_W-1:0] i_push_wa,
   input  logic [REG_DATA_W-1:0] i_push_wd,
   input  logic                  i_pop_en,
   input  logic                  i_squash_en,
   input  logic [REG_ADDR_W-1:0] i_squash_wa,
   output logic                  o_head_present_c,
   output logic                  o_head_valid_c,
   output logic [REG_ADDR_W-1:0] o_head_wa_c,
   output logic [REG_DATA_W-1:0] o_head_wd_c,
   output logic                  o_full_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic                  r_valid [DEPTH];
   logic [REG_ADDR_W-1:0] r_wa    [DEPTH];
   logic [REG_DATA_W-1:0] r_wd    [DEPTH];

   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_empty;
   logic w_push_ok;
   logic w_pop_ok;

   // Occupancy flags and guarded handshakes.
   assign w_empty   = (r_count == '0);
   assign o_full_c  = (r_count == CNT_W'(DEPTH));
   assign w_push_ok = i_push_en && !o_full_c;
   assign w_pop_ok  = i_pop_en && !w_empty;

   // Head view; a present head may carry a cleared tag.
   assign o_head_present_c = !w_empty;
   assign o_head_valid_c   = !w_empty && r_valid[r_rd_ptr];
   assign o_head_wa_c      = r_wa[r_rd_ptr];
   assign o_head_wd_c      = r_wd[r_rd_ptr];

   // Entry storage: squash matching tags, then write the new tail entry.
   always_ff @(posedge clk) begin
      if (rst_n == RST_ENABLE) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_valid[PTR_W'(i)] <= 1'b0;
            r_wa[PTR_W'(i)]    <= REG_NOP;
            r_wd[PTR_W'(i)]    <= ZERO_WORD;
         end
      end else begin
         if (i_squash_en) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (r_wa[PTR_W'(i)] == i_squash_wa) begin
                  r_valid[PTR_W'(i)] <= 1'b0;
               end
            end
         end
         if (w_push_ok) begin
            r_valid[r_wr_ptr] <= 1'b1;
            r_wa[r_wr_ptr]    <= i_push_wa;
            r_wd[r_wr_ptr]    <= i_push_wd;
         end
      end
   end

   // Wrapping pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (rst_n == RST_ENABLE) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges in-order pipeline results with buffered long-unit
// results onto the single regfile write port, one registered write per cycle.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH        = LU_FIFO_DEPTH,
   parameter int unsigned STARVE_LIMIT = LU_STARVE_LIMIT
)(
   input  logic         cpu_clk_50M,
   input  logic         cpu_rst_n,
   wb_arbiter_if.slave  bus
);

   localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

   logic                  w_mem_win;
   logic                  w_lu_ready;
   logic                  w_lu_accept;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_head_blocked;
   logic                  w_full;
   logic                  w_head_present;
   logic                  w_head_valid;
   logic [REG_ADDR_W-1:0] w_head_wa;
   logic [REG_DATA_W-1:0] w_head_wd;

   logic [REG_ADDR_W-1:0] r_wa;
   logic [REG_DATA_W-1:0] r_wd;
   logic                  r_we;
   logic                  r_stallreq;
   logic [SC_W-1:0]       r_starve_cnt;

   // Source decode: the pipeline always wins, and an equal-address long-unit
   // result arriving alongside it is older, so it is dropped after handshake.
   assign w_mem_win      = reg_write_req(bus.mem_wreg, bus.mem_wa);
   assign w_lu_ready     = !w_full && cpu_rst_n;
   assign w_lu_accept    = bus.lu_valid && w_lu_ready;
   assign w_push         = w_lu_accept && (bus.lu_wa != REG_NOP)
                           && !(w_mem_win && (bus.mem_wa == bus.lu_wa));
   assign w_pop          = w_head_present && (!w_head_valid || !w_mem_win);
   assign w_head_blocked = w_head_valid && w_mem_win;

   assign bus.lu_ready = w_lu_ready;
   assign bus.wa       = r_wa;
   assign bus.wd       = r_wd;
   assign bus.we       = r_we;
   assign bus.stallreq = r_stallreq;

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk              (cpu_clk_50M),
      .rst_n            (cpu_rst_n),
      .i_push_en        (w_push),
      .i_push_wa        (bus.lu_wa),
      .i_push_wd        (bus.lu_wd),
      .i_pop_en         (w_pop),
      .i_squash_en      (w_mem_win),
      .i_squash_wa      (bus.mem_wa),
      .o_head_present_c (w_head_present),
      .o_head_valid_c   (w_head_valid),
      .o_head_wa_c      (w_head_wa),
      .o_head_wd_c      (w_head_wd),
      .o_full_c         (w_full)
   );

   // Registered regfile write: pipeline first, then a valid FIFO head, else hold.
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst_n == RST_ENABLE) begin
         r_we <= WRITE_DISABLE;
         r_wa <= REG_NOP;
         r_wd <= ZERO_WORD;
      end else if (w_mem_win) begin
         r_we <= WRITE_ENABLE;
         r_wa <= bus.mem_wa;
         r_wd <= bus.mem_wd;
      end else if (w_head_valid) begin
         r_we <= WRITE_ENABLE;
         r_wa <= w_head_wa;
         r_wd <= w_head_wd;
      end else begin
         r_we <= WRITE_DISABLE;
      end
   end

   // Starvation watchdog: a one-cycle stall request after STARVE_LIMIT
   // consecutive cycles of the valid head losing to the pipeline.
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst_n == RST_ENABLE) begin
         r_starve_cnt <= '0;
         r_stallreq   <= 1'b0;
      end else if (w_head_blocked) begin
         if (r_starve_cnt == SC_W'(STARVE_LIMIT - 1)) begin
            r_starve_cnt <= '0;
            r_stallreq   <= 1'b1;
         end else begin
            r_starve_cnt <= r_starve_cnt + SC_W'(1);
            r_stallreq   <= 1'b0;
         end
      end else begin
         r_starve_cnt <= '0;
         r_stallreq   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic, all
// compared cycle by cycle against a queue-based reference model.
module tb_wb_arbiter;

   localparam int unsigned DEPTH        = 4;
   localparam int unsigned STARVE_LIMIT = 8;

   logic cpu_clk_50M = 1'b0;
   logic cpu_rst_n;

   wb_arbiter_if bus();

   wb_arbiter #(
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .cpu_clk_50M (cpu_clk_50M),
      .cpu_rst_n   (cpu_rst_n),
      .bus         (bus)
   );

   always #5 cpu_clk_50M = ~cpu_clk_50M;

   typedef struct {
      logic        v;
      logic [4:0]  wa;
      logic [31:0] wd;
   } ent_t;

   ent_t        q[$];
   logic        m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   logic        m_stall;
   int          m_starve;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   pulses;
   logic seen_aa;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic mw, input logic [4:0] mwa, input logic [31:0] mwd,
                        input logic lv, input logic [4:0] lwa, input logic [31:0] lwd);
      bus.mem_wreg = mw;
      bus.mem_wa   = mwa;
      bus.mem_wd   = mwd;
      bus.lu_valid = lv;
      bus.lu_wa    = lwa;
      bus.lu_wd    = lwd;
   endtask

   // Reference model: one clock of behaviour given the currently driven inputs.
   task automatic model_cycle();
      logic win, ready, hp, hv;
      if (cpu_rst_n !== 1'b1) begin
         q.delete();
         m_starve = 0;
         m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_stall = 1'b0;
         return;
      end
      win   = bus.mem_wreg && (bus.mem_wa != 5'd0);
      ready = (q.size() < DEPTH);
      hp    = (q.size() > 0);
      hv    = hp && q[0].v;
      if (win) begin
         m_we = 1'b1; m_wa = bus.mem_wa; m_wd = bus.mem_wd;
      end else if (hv) begin
         m_we = 1'b1; m_wa = q[0].wa; m_wd = q[0].wd;
      end else begin
         m_we = 1'b0;
      end
      m_stall = 1'b0;
      if (hv && win) begin
         if (m_starve == STARVE_LIMIT - 1) begin
            m_stall  = 1'b1;
            m_starve = 0;
         end else begin
            m_starve++;
         end
      end else begin
         m_starve = 0;
      end
      if (hp && (!q[0].v || !win)) void'(q.pop_front());
      if (win) begin
         foreach (q[i]) if (q[i].v && q[i].wa == bus.mem_wa) q[i].v = 1'b0;
      end
      if (bus.lu_valid && ready && bus.lu_wa != 5'd0 && !(win && bus.mem_wa == bus.lu_wa))
         q.push_back('{1'b1, bus.lu_wa, bus.lu_wd});
   endtask

   // One clock: check the combinational ready, advance model, check registered outputs.
   task automatic step(input string tag);
      #1;
      check({tag, ":lu_ready"}, 32'(bus.lu_ready), 32'(cpu_rst_n && (q.size() < DEPTH)));
      model_cycle();
      @(posedge cpu_clk_50M);
      #1;
      check({tag, ":we"},       32'(bus.we),       32'(m_we));
      check({tag, ":wa"},       32'(bus.wa),       32'(m_wa));
      check({tag, ":wd"},       bus.wd,            m_wd);
      check({tag, ":stallreq"}, 32'(bus.stallreq), 32'(m_stall));
      if (bus.stallreq === 1'b1) pulses++;
      if (bus.wd === 32'hAA) seen_aa = 1'b1;
   endtask

   initial begin
      pulses  = 0;
      seen_aa = 1'b0;

      // Reset held three cycles with both sources requesting.
      cpu_rst_n = 1'b0;
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      repeat (3) step("t1_rst");
      cpu_rst_n = 1'b1;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      step("t1_release");

      // Pipeline-only writes, including the r0 no-op.
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
      step("t2_pipe");
      check("t2_pipe_wd_const", bus.wd, 32'hDEADBEEF);
      drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
      step("t2_r0");
      check("t2_r0_we_const", 32'(bus.we), 32'd0);

      // Priority then drain.
      drive(1'b1, 5'd7, 32'h22, 1'b1, 5'd3, 32'h11);
      step("t3_prio");
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      step("t3_drain");
      check("t3_drain_wd_const", bus.wd, 32'h11);
      step("t3_idle");

      // WAW squash.
      seen_aa = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hAA);
      step("t4_push");
      drive(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'd0);
      step("t4_pipe");
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      repeat (2) step("t4_idle");
      check("t4_no_stale_aa", 32'(seen_aa), 32'd0);

      // Fill under pipeline pressure until the starvation stall fires.
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 5'(20 + i), 32'(32'h100 + i), 1'b1, 5'(10 + i), 32'(32'h500 + i));
         step("t5_fill");
      end
      for (int k = 0; k < 20; k++) begin
         if (pulses != 0) break;
         drive(1'b1, 5'(20 + (k % 8)), 32'(32'h200 + k), 1'b0, 5'd0, 32'd0);
         step("t5_block");
      end
      check("t5_stall_pulses", 32'(pulses), 32'd1);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      step("t5_after_stall");
      check("t5_head_wa_const", 32'(bus.wa), 32'd10);
      repeat (4) step("t5_drain");
      check("t5_single_pulse", 32'(pulses), 32'd1);

      // Same-cycle conflict and r0 push.
      drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h99);
      step("t6_conflict");
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      step("t6_conflict_idle");
      check("t6_no_enqueue_we", 32'(bus.we), 32'd0);
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
      step("t6_r0_push");
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      step("t6_r0_idle");
      check("t6_r0_we", 32'(bus.we), 32'd0);

      // Random traffic with small address space for collisions and squashes.
      for (int n = 0; n < 600; n++) begin
         cpu_rst_n    = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         bus.mem_wreg = ($urandom_range(0, 99) < 65);
         bus.mem_wa   = 5'($urandom_range(0, 7));
         bus.mem_wd   = $urandom;
         bus.lu_valid = ($urandom_range(0, 99) < 60);
         bus.lu_wa    = 5'($urandom_range(0, 7));
         bus.lu_wd    = $urandom;
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
